// File: rtl/log_pkg.sv
// Severity levels shared by the event logger and software-visible headers,
// plus the threshold compare used to filter events.
package log_pkg;

    typedef enum logic [1:0] {
        DEBUG = 2'd0,
        INFO  = 2'd1,
        WARN  = 2'd2,
        ERROR = 2'd3
    } log_level_e;

    localparam int LEVEL_W = 2;

    function automatic logic level_passes(input log_level_e level, input log_level_e thr);
        return level >= thr;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
// The start pointer only moves on a grant that is not held back.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] grant
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] start_q;
    logic [PW-1:0] start_d;

    always_comb begin
        int   idx;
        int   nxt;
        logic found;
        grant   = '0;
        start_d = start_q;
        found   = 1'b0;
        nxt     = 0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start_q) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                nxt        = (idx + 1) % N;
            end
        end
        if (found && !hold) begin
            start_d = PW'(nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q <= '0;
        end else begin
            start_q <= start_d;
        end
    end

endmodule

// File: rtl/log_event_buffer.sv
// Severity-filtered multi-channel event logger: qualifying events are
// timestamped, arbitrated round-robin and queued in a show-ahead FIFO.
module log_event_buffer
    import log_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int MSG_W        = 16,
    parameter int DEPTH        = 16,
    parameter int TS_W         = 16,
    parameter int DROP_ON_FULL = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        enable,
    input  logic [1:0]                                  level_thr,
    input  logic [N_CH-1:0]                             ev_valid,
    input  logic [N_CH*2-1:0]                           ev_level,
    input  logic [N_CH*MSG_W-1:0]                       ev_msg,
    output logic [N_CH-1:0]                             ev_ready,
    output logic                                        rd_valid,
    input  logic                                        rd_ready,
    output logic [TS_W+$clog2(N_CH)+2+MSG_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]                      fill,
    output logic [15:0]                                 drop_cnt
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int AW     = $clog2(DEPTH);
    localparam int FILL_W = AW + 1;
    localparam int REC_W  = TS_W + CH_W + 2 + MSG_W;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [15:0]       drop_q, drop_d;

    logic [REC_W-1:0]  mem [DEPTH];

    logic [N_CH-1:0]   qual;
    logic [N_CH-1:0]   grant;
    logic              full;
    logic              hold;
    logic              any_grant;
    logic              push;
    logic              drop;
    logic              pop;
    logic [REC_W-1:0]  wr_rec;

    // Full uses the registered fill, so a pop never frees a slot for the same cycle.
    assign full      = (fill_q == FILL_W'(DEPTH));
    assign hold      = full && (DROP_ON_FULL == 0);
    assign any_grant = |grant;
    assign push      = any_grant && !full;
    assign drop      = any_grant && full && (DROP_ON_FULL != 0);
    assign pop       = (fill_q != '0) && rd_ready;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign qual[gi] = enable && ev_valid[gi] &&
                              level_passes(log_level_e'(ev_level[2*gi +: 2]),
                                           log_level_e'(level_thr));
            assign ev_ready[gi] = !qual[gi] || (grant[gi] && !hold);
        end
    endgenerate

    rr_arbiter #(
        .N(N_CH)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (qual),
        .hold (hold),
        .grant(grant)
    );

    always_comb begin
        wr_rec = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                wr_rec = {ts_q, CH_W'(i), ev_level[2*i +: 2], ev_msg[MSG_W*i +: MSG_W]};
            end
        end
    end

    always_comb begin
        ts_d     = ts_q + 1'b1;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d   = fill_q + FILL_W'(push) - FILL_W'(pop);
        drop_d   = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q     <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            ts_q     <= ts_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_q] <= wr_rec;
        end
    end

    assign rd_valid = (fill_q != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
    assign fill     = fill_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_log_event_buffer.sv
// Scoreboard bench: u_dut0 (drop mode, 8-bit timestamp so wrap is reachable)
// and u_dut1 (backpressure mode) share clock and reset.
module tb_log_event_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en0 = 1'b1, rready0 = 1'b0;
    logic [1:0]  thr0 = 2'd0;
    logic [3:0]  v0 = '0, rdy0;
    logic [7:0]  lvl0 = '0;
    logic [63:0] msg0 = '0;
    logic        rvalid0;
    logic [27:0] rdata0;
    logic [4:0]  fill0;
    logic [15:0] drop0;

    logic        en1 = 1'b1, rready1 = 1'b0;
    logic [1:0]  thr1 = 2'd0;
    logic [3:0]  v1 = '0, rdy1;
    logic [7:0]  lvl1 = 8'hFF;
    logic [63:0] msg1 = '0;
    logic        rvalid1;
    logic [35:0] rdata1;
    logic [4:0]  fill1;
    logic [15:0] drop1;

    log_event_buffer #(.N_CH(4), .MSG_W(16), .DEPTH(16), .TS_W(8), .DROP_ON_FULL(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .level_thr(thr0),
        .ev_valid(v0), .ev_level(lvl0), .ev_msg(msg0), .ev_ready(rdy0),
        .rd_valid(rvalid0), .rd_ready(rready0), .rd_data(rdata0),
        .fill(fill0), .drop_cnt(drop0)
    );

    log_event_buffer #(.N_CH(4), .MSG_W(16), .DEPTH(16), .TS_W(16), .DROP_ON_FULL(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en1), .level_thr(thr1),
        .ev_valid(v1), .ev_level(lvl1), .ev_msg(msg1), .ev_ready(rdy1),
        .rd_valid(rvalid1), .rd_ready(rready1), .rd_data(rdata1),
        .fill(fill1), .drop_cnt(drop1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [27:0] sb0[$];
    logic [7:0]  ts_exp = '0;

    always @(posedge clk) ts_exp <= rst_n ? ts_exp + 8'd1 : 8'd0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called just after a falling edge with dut0 inputs already driven.
    task automatic step0(input logic [3:0] exp_rdy, input int push_ch);
        logic [27:0] exp_rec;
        #1;
        check_eq("ev_ready0", rdy0, exp_rdy);
        if (rready0 && rvalid0) begin
            if (sb0.size() == 0) begin
                check_eq("rd_unexpected0", 1, 0);
            end else begin
                exp_rec = sb0.pop_front();
                check_eq("rd_data0", rdata0, exp_rec);
            end
        end
        if (push_ch >= 0) begin
            sb0.push_back({ts_exp, 2'(push_ch), lvl0[push_ch*2 +: 2], msg0[push_ch*16 +: 16]});
        end
        @(negedge clk);
        check_eq("fill0", fill0, sb0.size());
        check_eq("rd_valid0", rvalid0, sb0.size() != 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; v0 = '0; v1 = '0; rready0 = 1'b0; rready1 = 1'b0;
        repeat (2) @(negedge clk);
        sb0.delete();
        check_eq("rst_fill0", fill0, 0);
        check_eq("rst_rd_valid0", rvalid0, 0);
        check_eq("rst_rd_data0", rdata0, 0);
        check_eq("rst_drop0", drop0, 0);
        check_eq("rst_fill1", fill1, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] rec;
        int k;

        // Basic write at ts=5
        do_reset();
        while (ts_exp != 8'd5) step0(4'hF, -1);
        thr0 = 2'd0; v0 = 4'b0100; lvl0 = 8'b0001_0000; msg0 = 64'h0000_00AB_0000_0000;
        step0(4'hF, 2);
        v0 = '0;
        rec = {8'd5, 2'd2, 2'd1, 16'h00AB};
        check_eq("first_record", rdata0, rec);
        rready0 = 1'b1; step0(4'hF, -1); rready0 = 1'b0;

        // Filtering and enable=0
        thr0 = 2'd2; v0 = 4'hF; lvl0 = 8'h55;
        step0(4'hF, -1);
        check_eq("filter_drop0", drop0, 0);
        en0 = 1'b0; lvl0 = 8'hFF;
        step0(4'hF, -1);
        en0 = 1'b1; v0 = '0;

        // Round-robin from reset: grants 0,1,2,3
        do_reset();
        thr0 = 2'd2; lvl0 = 8'hFF; msg0 = 64'h1003_1002_1001_1000;
        for (k = 0; k < 4; k++) begin
            v0 = 4'(15 & ~((1 << k) - 1));
            step0(4'((2 << k) - 1), k);
        end
        v0 = '0; rready0 = 1'b1;
        repeat (4) step0(4'hF, -1);
        rready0 = 1'b0;

        // Drop on full: 20 events, 16 stored, 4 dropped
        thr0 = 2'd0; v0 = 4'b0001;
        for (k = 0; k < 20; k++) begin
            msg0[15:0] = 16'h2000 + 16'(k);
            step0(4'hF, (k < 16) ? 0 : -1);
        end
        v0 = '0;
        check_eq("drop_cnt_after_20", drop0, 4);
        rready0 = 1'b1;
        repeat (16) step0(4'hF, -1);
        rready0 = 1'b0;

        // Backpressure mode on u_dut1
        thr1 = 2'd0; v1 = 4'b0001;
        for (k = 0; k < 16; k++) begin
            msg1[15:0] = 16'(k);
            #1; check_eq("bp_fill_ready", rdy1, 4'hF);
            @(negedge clk);
        end
        v1 = 4'b0010;
        #1; check_eq("bp_full", fill1, 16);
        check_eq("bp_held_a", rdy1, 4'b1101);
        @(negedge clk);
        #1; check_eq("bp_held_b", rdy1, 4'b1101);
        rready1 = 1'b1;
        #1; check_eq("bp_pop_cycle_ready", rdy1, 4'b1101);
        check_eq("bp_head_msg", rdata1[15:0], 16'h0000);
        check_eq("bp_head_ch_lvl", rdata1[19:16], 4'b0011);
        @(negedge clk);
        rready1 = 1'b0;
        #1; check_eq("bp_fill_after_pop", fill1, 15);
        check_eq("bp_accept_next", rdy1, 4'hF);
        check_eq("bp_new_head", rdata1[15:0], 16'h0001);
        @(negedge clk);
        v1 = '0;
        #1; check_eq("bp_refilled", fill1, 16);
        check_eq("bp_no_drop", drop1, 0);
        @(negedge clk);

        // Steady push/pop at fill=8 across a timestamp wrap
        while (ts_exp != 8'd200) step0(4'hF, -1);
        v0 = 4'b0001; lvl0 = 8'hFF;
        for (k = 0; k < 8; k++) begin
            msg0[15:0] = 16'h3000 + 16'(k);
            step0(4'hF, 0);
        end
        rready0 = 1'b1;
        for (k = 0; k < 100; k++) begin
            msg0[15:0] = 16'h4000 + 16'(k);
            step0(4'hF, 0);
        end
        v0 = '0;
        repeat (8) step0(4'hF, -1);
        rready0 = 1'b0;

        // Mid-operation reset with fill=10, drop_cnt=3
        do_reset();
        v0 = 4'b0001;
        for (k = 0; k < 19; k++) begin
            msg0[15:0] = 16'h6000 + 16'(k);
            step0(4'hF, (k < 16) ? 0 : -1);
        end
        v0 = '0; rready0 = 1'b1;
        repeat (6) step0(4'hF, -1);
        rready0 = 1'b0;
        check_eq("pre_rst_fill", fill0, 10);
        check_eq("pre_rst_drop", drop0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        sb0.delete();
        check_eq("midrst_fill", fill0, 0);
        check_eq("midrst_rd_valid", rvalid0, 0);
        check_eq("midrst_rd_data", rdata0, 0);
        check_eq("midrst_drop", drop0, 0);
        rst_n = 1'b1;
        v0 = 4'b0001; msg0[15:0] = 16'h5555;
        step0(4'hF, 0);
        v0 = '0;
        check_eq("ts_restart", rdata0[27:20], 8'd0);
        rready0 = 1'b1; step0(4'hF, -1); rready0 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
